regfile_xfer_arbiter: RTL

Shares the 11-entry register file (R, row, cAT, cB, rnow, cATnow, cBnow, alphap, betap, gammap, Total) between several requesters, such as the main control unit and a debug/loader port. Each requester posts one transfer command. The block arbitrates, then drives the register file's one-hot read_en/write_en and the bus datain through a fixed multi-cycle sequence. Each transfer completes with a done or error response to the requester that issued it.

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/regfile_xfer_arbiter_rr_arbiter.sv | 66 ++++++
 rtl/regfile_xfer_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file transfer arbiter: register map,
// transfer op encoding and sequencer states.
package regfile_pkg;

    localparam int REG_R      = 0;
    localparam int REG_ROW    = 1;
    localparam int REG_CAT    = 2;
    localparam int REG_CB     = 3;
    localparam int REG_RNOW   = 4;
    localparam int REG_CATNOW = 5;
    localparam int REG_CBNOW  = 6;
    localparam int REG_ALPHAP = 7;
    localparam int REG_BETAP  = 8;
    localparam int REG_GAMMAP = 9;
    localparam int REG_TOTAL  = 10;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

endpackage

// File: rtl/regfile_xfer_arbiter_rr_arbiter.sv
// Requester arbiter: round-robin when RR_ARB_EN is defined,
// otherwise fixed priority with the lowest index winning.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic            found;
    logic [ID_W-1:0] k;

`ifdef RR_ARB_EN
    logic [ID_W-1:0] ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= id;
    end

    // Search begins just past the last winner
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                id       = k;
            end
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, reset, advance};

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = ID_W'(i);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                id       = k;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_xfer_arbiter.sv
// Multi-requester transfer sequencer for the 11-entry register file.
// Arbitration policy selected by RR_ARB_EN (see rr_arbiter).
module regfile_xfer_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int REG_COUNT = 11,
    parameter int REG_WIDTH = 12,
    parameter int IDX_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [2*NUM_REQ-1:0]         req_op,
    input  logic [IDX_W*NUM_REQ-1:0]     req_src,
    input  logic [IDX_W*NUM_REQ-1:0]     req_dst,
    input  logic [REG_WIDTH*NUM_REQ-1:0] req_imm,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic                         rsp_err,
    output logic [REG_WIDTH-1:0]         rsp_data,
    output logic [REG_COUNT-1:0]         read_en,
    output logic [REG_COUNT-1:0]         write_en,
    output logic [REG_WIDTH-1:0]         datain,
    input  logic [REG_WIDTH-1:0]         dataout,
    output logic                         busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e               state, state_nx;
    logic [ID_W-1:0]      win_q, win_id;
    logic [NUM_REQ-1:0]   grant;
    op_e                  op_q;
    logic [IDX_W-1:0]     src_q, dst_q;
    logic [REG_WIDTH-1:0] imm_q, hold_q, datain_q;
    logic                 err_q;
    logic                 accept;
    logic                 src_bad, dst_bad, cmd_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .id      (win_id)
    );

    assign accept = (state == S_IDLE) && (|req_valid) && !reset;

    // Extra bit keeps the range test correct when REG_COUNT == 2**IDX_W
    assign src_bad = {1'b0, src_q} >= (IDX_W+1)'(REG_COUNT);
    assign dst_bad = {1'b0, dst_q} >= (IDX_W+1)'(REG_COUNT);
    assign cmd_err = (op_q == OP_RSVD)
                   || (op_q != OP_LOAD && src_bad)
                   || (op_q != OP_STORE && dst_bad);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            win_q    <= '0;
            op_q     <= OP_MOVE;
            src_q    <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            hold_q   <= '0;
            datain_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                win_q <= win_id;
                op_q  <= op_e'(req_op[int'(win_id)*2 +: 2]);
                src_q <= req_src[int'(win_id)*IDX_W +: IDX_W];
                dst_q <= req_dst[int'(win_id)*IDX_W +: IDX_W];
                imm_q <= req_imm[int'(win_id)*REG_WIDTH +: REG_WIDTH];
                err_q <= 1'b0;
            end
            if (state == S_GRANT) begin
                if (cmd_err)
                    err_q <= 1'b1;
                else if (op_q == OP_LOAD)
                    hold_q <= imm_q;
            end
            if (state == S_READ)
                hold_q <= dataout;
            if (state == S_WRITE)
                datain_q <= hold_q;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        read_en   = '0;
        write_en  = '0;
        datain    = datain_q;
        busy      = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    req_ready = grant;
                    state_nx  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (cmd_err)
                    state_nx = S_RESP;
                else if (op_q == OP_LOAD)
                    state_nx = S_WRITE;
                else
                    state_nx = S_READ;
            end
            S_READ: begin
                read_en  = REG_COUNT'(1) << src_q;
                state_nx = (op_q == OP_MOVE) ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                write_en = REG_COUNT'(1) << dst_q;
                datain   = hold_q;
                state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid = NUM_REQ'(1) << win_q;
                rsp_err   = err_q;
                rsp_data  = (err_q || op_q == OP_LOAD) ? '0 : hold_q;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
